// File: rtl/lfsr_pkg.sv
// Shared definitions for the XNOR Fibonacci LFSR generator/checker pair:
// tap table, checker FSM encoding and a generic successor function.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Single tap position (1-based) as a one-hot mask bit.
  function automatic logic [63:0] tap(input int t);
    return 64'd1 << (t - 1);
  endfunction

  // Tap mask for an n-bit XNOR LFSR; bit t-1 set means tap position t.
  function automatic logic [63:0] TAPS(input int n);
    logic [63:0] m;
    m = '0;
    case (n)
      3:  m = tap(3)  | tap(2);
      4:  m = tap(4)  | tap(3);
      5:  m = tap(5)  | tap(3);
      6:  m = tap(6)  | tap(5);
      7:  m = tap(7)  | tap(6);
      8:  m = tap(8)  | tap(6)  | tap(5)  | tap(4);
      9:  m = tap(9)  | tap(5);
      10: m = tap(10) | tap(7);
      11: m = tap(11) | tap(9);
      12: m = tap(12) | tap(6)  | tap(4)  | tap(1);
      13: m = tap(13) | tap(4)  | tap(3)  | tap(1);
      14: m = tap(14) | tap(5)  | tap(3)  | tap(1);
      15: m = tap(15) | tap(14);
      16: m = tap(16) | tap(15) | tap(13) | tap(4);
      17: m = tap(17) | tap(14);
      18: m = tap(18) | tap(11);
      19: m = tap(19) | tap(6)  | tap(2)  | tap(1);
      20: m = tap(20) | tap(17);
      21: m = tap(21) | tap(19);
      22: m = tap(22) | tap(21);
      23: m = tap(23) | tap(18);
      24: m = tap(24) | tap(23) | tap(22) | tap(17);
      25: m = tap(25) | tap(22);
      26: m = tap(26) | tap(6)  | tap(2)  | tap(1);
      27: m = tap(27) | tap(5)  | tap(2)  | tap(1);
      28: m = tap(28) | tap(25);
      29: m = tap(29) | tap(27);
      30: m = tap(30) | tap(6)  | tap(4)  | tap(1);
      31: m = tap(31) | tap(28);
      32: m = tap(32) | tap(22) | tap(2)  | tap(1);
      64: m = tap(64) | tap(63) | tap(61) | tap(60);
      default: m = '0;
    endcase
    return m;
  endfunction

  // Successor of an n-bit word held right-aligned in 64 bits; upper bits cleared.
  function automatic logic [63:0] lfsr_succ(input logic [63:0] x, input int n);
    logic [63:0] keep;
    keep = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    return ((x << 1) | {63'd0, ~^(x & TAPS(n))}) & keep;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational successor of an XNOR Fibonacci LFSR word, shared with the generator.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS = 32
) (
  input  logic [NUM_BITS-1:0] x,
  output logic [NUM_BITS-1:0] y
);

  localparam logic [63:0]         FULL_MASK = TAPS(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAP_MASK  = FULL_MASK[NUM_BITS-1:0];

  // Shift left and insert the XNOR of the tapped bits at bit 0.
  always_comb begin
    y = {x[NUM_BITS-2:0], ~^(x & TAP_MASK)};
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for an XNOR LFSR stream: predicts each word from
// the previous one, locks after a run of good words, flags and counts errors.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS   = 32,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_Enable,
  input  logic                i_Valid,
  input  logic [NUM_BITS-1:0] i_Data,
  input  logic                i_Clear,
  output logic                o_Locked,
  output logic                o_Err,
  output logic [CNT_W-1:0]    o_Err_Count,
  output logic [CNT_W-1:0]    o_Word_Count
);

  localparam logic [8:0] LOCK_TARGET = 9'(LOCK_COUNT);
  localparam logic [8:0] LOSS_TARGET = 9'(LOSS_COUNT);

  state_t              state;
  logic [NUM_BITS-1:0] r_Prev;
  logic [NUM_BITS-1:0] predicted;
  logic [7:0]          run;
  logic [7:0]          bad;
  logic [8:0]          run_next;
  logic [8:0]          bad_next;
  logic                good;

  lfsr_next #(
    .NUM_BITS(NUM_BITS)
  ) u_next (
    .x(r_Prev),
    .y(predicted)
  );

  // Compare the incoming word with the prediction and precompute streak increments.
  always_comb begin
    good     = (i_Data == predicted);
    run_next = {1'b0, run} + 9'd1;
    bad_next = {1'b0, bad} + 9'd1;
  end

  // Checker FSM with registered outputs; r_Prev re-seeds from every accepted word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      r_Prev       <= '0;
      run          <= '0;
      bad          <= '0;
      o_Locked     <= 1'b0;
      o_Err        <= 1'b0;
      o_Err_Count  <= '0;
      o_Word_Count <= '0;
    end else begin
      o_Err <= 1'b0;
      if (i_Enable) begin
        if (i_Valid) begin
          r_Prev <= i_Data;
        end
        if (i_Clear) begin
          state        <= SYNC;
          run          <= '0;
          bad          <= '0;
          o_Locked     <= 1'b0;
          o_Err_Count  <= '0;
          o_Word_Count <= '0;
        end else if (i_Valid) begin
          case (state)
            IDLE: begin
              state <= SYNC;
              run   <= '0;
            end
            SYNC: begin
              if (good) begin
                if (run_next == LOCK_TARGET) begin
                  state    <= LOCKED;
                  o_Locked <= 1'b1;
                  run      <= '0;
                  bad      <= '0;
                end else begin
                  run <= run_next[7:0];
                end
              end else begin
                run <= '0;
              end
            end
            LOCKED: begin
              if (o_Word_Count != '1) begin
                o_Word_Count <= o_Word_Count + 1'b1;
              end
              if (good) begin
                bad <= '0;
              end else begin
                o_Err <= 1'b1;
                if (o_Err_Count != '1) begin
                  o_Err_Count <= o_Err_Count + 1'b1;
                end
                if (bad_next == LOSS_TARGET) begin
                  state    <= SYNC;
                  o_Locked <= 1'b0;
                  run      <= '0;
                  bad      <= '0;
                end else begin
                  bad <= bad_next[7:0];
                end
              end
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule
